// File: rtl/nes_pad_reader_if.sv
// Signal bundle between the NES pad reader and the rest of the console:
// the pad header pins plus the decoded pad word and its status flags.
interface nes_pad_reader_if;
    logic       poll_req;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] pad;
    logic       pad_valid;
    logic       busy;

    // master: the reader, which drives the pad header and publishes the reading
    modport master (
        input  poll_req,
        input  pad_data,
        output pad_latch,
        output pad_clk,
        output pad,
        output pad_valid,
        output busy
    );

    modport slave (
        output poll_req,
        output pad_data,
        input  pad_latch,
        input  pad_clk,
        input  pad,
        input  pad_valid,
        input  busy
    );
endinterface

// File: rtl/nes_pad_reader.sv
// Console-side reader for a 4021-based NES gamepad: generates LATCH/CLK, samples
// DATA, and publishes {Right,Left,Down,Up,Start,Select,B,A} active-high.
module nes_pad_reader #(
    parameter int POLL_CYCLES  = 1666667,
    parameter int LATCH_CYCLES = 1200,
    parameter int HALF_CYCLES  = 600
) (
    input  logic               CLK100MHz,
    input  logic               CPU_RESETN,
    nes_pad_reader_if.master   pad_bus
);

    localparam int POLL_W  = $clog2(POLL_CYCLES);
    localparam int CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic                low_q, low_d;
    logic [7:0]          shift_q, shift_d;
    logic [1:0]          sync_q;
    logic                latch_q, latch_d;
    logic                pclk_q, pclk_d;
    logic [7:0]          pad_q, pad_d;
    logic                valid_q, valid_d;

    logic tick;
    logic sample;

    // Pad drives DATA low for a pressed button, so every sample is inverted.
    assign sample = ~sync_q[1];
    assign tick   = (poll_q == POLL_LAST);

    always_ff @(posedge CLK100MHz or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pad_bus.pad_data};
        end
    end

    always_ff @(posedge CLK100MHz or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= S_IDLE;
            poll_q  <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            low_q   <= 1'b0;
            shift_q <= '0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
            pad_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            low_q   <= low_d;
            shift_q <= shift_d;
            latch_q <= latch_d;
            pclk_q  <= pclk_d;
            pad_q   <= pad_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        poll_d  = tick ? '0 : poll_q + POLL_W'(1);
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        low_d   = low_q;
        shift_d = shift_q;

        case (state_q)
            S_IDLE: begin
                // Restarting the poll counter keeps the auto tick out of a running transaction.
                if (tick || pad_bus.poll_req) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                    poll_d  = '0;
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    low_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!low_q) begin
                        // Sample at the end of the high phase, well after the previous shift settled.
                        shift_d[bit_q] = sample;
                        low_d          = 1'b1;
                    end else begin
                        low_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            state_d = S_DONE;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pin outputs are registered from the next state so they line up with the state register.
        latch_d = (state_d == S_LATCH);
        pclk_d  = !((state_d == S_SHIFT) && low_d);
        valid_d = (state_d == S_DONE);
        pad_d   = (state_d == S_DONE) ? shift_d : pad_q;
    end

    assign pad_bus.pad_latch = latch_q;
    assign pad_bus.pad_clk   = pclk_q;
    assign pad_bus.pad       = pad_q;
    assign pad_bus.pad_valid = valid_q;
    assign pad_bus.busy      = (state_q != S_IDLE);

endmodule
